// File: rtl/xalu_ctrl.sv
// -----------------------------------------------------------------------------
// xalu_ctrl : sequencer for the shared multiply/divide unit and owner of HI/LO.
//
// One op is accepted at a time. Multiplies compute the full 64-bit product at
// accept and then hold busy for MUL_LAT cycles. Divides run a restoring radix-2
// divider (one quotient bit per cycle) followed by a sign fix-up cycle.
// A flush aborts any in-flight op without touching hi, lo or mul_result.
//
// Optional feature macro: XALU_DIV_ZERO_FAST_EN
//    defined     : DIV/DIVU with src_b == 0 go straight to the fix-up cycle and
//                  write the divide-by-zero result after a single busy cycle.
//    not defined : divide-by-zero runs the full DIV_STEPS+1 cycle sequence.
// -----------------------------------------------------------------------------
module xalu_ctrl #(
   parameter int MUL_LAT   = 4,
   parameter int DIV_STEPS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        mul_valid,
   output logic [31:0] mul_result
);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MUL   = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_LAT - 1);
   localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   // Architectural and sequencing state
   state_t      state_q,      state_d;
   logic [5:0]  cnt_q,        cnt_d;
   logic [31:0] hi_q,         hi_d;
   logic [31:0] lo_q,         lo_d;
   logic        mul_valid_q,  mul_valid_d;
   logic [31:0] mul_result_q, mul_result_d;

   // Multiply datapath state
   logic [63:0] prod_q,       prod_d;
   logic        mul32_q,      mul32_d;      // 1: MUL (result to mul_result), 0: MULT/MULTU

   // Divide datapath state
   logic [32:0] rem_q,        rem_d;        // partial remainder
   logic [31:0] quo_q,        quo_d;        // dividend bits shift out, quotient bits shift in
   logic [31:0] div_b_q,      div_b_d;      // magnitude of divisor
   logic [31:0] a_raw_q,      a_raw_d;      // original dividend for the divide-by-zero result
   logic        neg_quo_q,    neg_quo_d;
   logic        neg_rem_q,    neg_rem_d;
   logic        div_zero_q,   div_zero_d;

   // Combinational helpers
   logic        accept;
   logic        div_signed;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [63:0] prod_signed;
   logic [63:0] prod_unsigned;
   logic [33:0] rem_shift;
   logic [33:0] trial;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign busy       = (state_q != ST_IDLE);
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign mul_valid  = mul_valid_q;
   assign mul_result = mul_result_q;

   // Operand conditioning, product, one restoring step and sign fix-up values
   always_comb begin
      accept        = op_valid && (state_q == ST_IDLE) && !flush && (op != OP_RSVD);
      div_signed    = (op == OP_DIV);
      abs_a         = (div_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
      abs_b         = (div_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;
      prod_signed   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
      prod_unsigned = {32'd0, src_a} * {32'd0, src_b};
      // Remainder is always below the divisor, so the shifted value fits in 33 bits;
      // the extra top bit makes the trial-subtract borrow unambiguous.
      rem_shift     = {rem_q, quo_q[31]};
      trial         = rem_shift - {2'b00, div_b_q};
      quo_fix       = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
      rem_fix       = neg_rem_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
   end

   // Next-state logic for the sequencer and all datapath registers
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      mul_valid_d  = 1'b0;
      mul_result_d = mul_result_q;
      prod_d       = prod_q;
      mul32_d      = mul32_q;
      rem_d        = rem_q;
      quo_d        = quo_q;
      div_b_d      = div_b_q;
      a_raw_d      = a_raw_q;
      neg_quo_d    = neg_quo_q;
      neg_rem_d    = neg_rem_q;
      div_zero_d   = div_zero_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op)
                  OP_MTHI: hi_d = src_a;
                  OP_MTLO: lo_d = src_a;
                  OP_MULT, OP_MUL: begin
                     prod_d  = prod_signed;
                     mul32_d = (op == OP_MUL);
                     cnt_d   = MUL_CNT_INIT;
                     state_d = ST_MUL;
                  end
                  OP_MULTU: begin
                     prod_d  = prod_unsigned;
                     mul32_d = 1'b0;
                     cnt_d   = MUL_CNT_INIT;
                     state_d = ST_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     rem_d      = 33'd0;
                     quo_d      = abs_a;
                     div_b_d    = abs_b;
                     a_raw_d    = src_a;
                     neg_quo_d  = div_signed && (src_a[31] ^ src_b[31]);
                     neg_rem_d  = div_signed && src_a[31];
                     div_zero_d = (src_b == 32'd0);
                     cnt_d      = DIV_CNT_INIT;
`ifdef XALU_DIV_ZERO_FAST_EN
                     state_d    = (src_b == 32'd0) ? ST_FIX : ST_DIV;
`else
                     state_d    = ST_DIV;
`endif
                  end
                  default: ;
               endcase
            end
         end

         ST_MUL: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 6'd0) begin
               if (mul32_q) begin
                  mul_result_d = prod_q[31:0];
                  mul_valid_d  = 1'b1;
               end else begin
                  hi_d = prod_q[63:32];
                  lo_d = prod_q[31:0];
               end
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end

         ST_DIV: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               if (!trial[33]) begin
                  rem_d = trial[32:0];
                  quo_d = {quo_q[30:0], 1'b1};
               end else begin
                  rem_d = rem_shift[32:0];
                  quo_d = {quo_q[30:0], 1'b0};
               end
               if (cnt_q == 6'd0) begin
                  state_d = ST_FIX;
               end else begin
                  cnt_d = cnt_q - 6'd1;
               end
            end
         end

         ST_FIX: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               if (div_zero_q) begin
                  lo_d = 32'hFFFF_FFFF;
                  hi_d = a_raw_q;
               end else begin
                  lo_d = quo_fix;
                  hi_d = rem_fix;
               end
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 6'd0;
         hi_q         <= 32'd0;
         lo_q         <= 32'd0;
         mul_valid_q  <= 1'b0;
         mul_result_q <= 32'd0;
         prod_q       <= 64'd0;
         mul32_q      <= 1'b0;
         rem_q        <= 33'd0;
         quo_q        <= 32'd0;
         div_b_q      <= 32'd0;
         a_raw_q      <= 32'd0;
         neg_quo_q    <= 1'b0;
         neg_rem_q    <= 1'b0;
         div_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         mul_valid_q  <= mul_valid_d;
         mul_result_q <= mul_result_d;
         prod_q       <= prod_d;
         mul32_q      <= mul32_d;
         rem_q        <= rem_d;
         quo_q        <= quo_d;
         div_b_q      <= div_b_d;
         a_raw_q      <= a_raw_d;
         neg_quo_q    <= neg_quo_d;
         neg_rem_q    <= neg_rem_d;
         div_zero_q   <= div_zero_d;
      end
   end

endmodule

// File: tb/tb_xalu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xalu_ctrl : self-checking bench for xalu_ctrl.
// A transaction-level model (busy countdown plus results from plain arithmetic)
// is stepped on every rising edge; a negedge process compares all outputs to it.
// Directed ops carry literal expectations; a random phase follows.
// -----------------------------------------------------------------------------
module tb_xalu_ctrl;

   localparam int MUL_LAT   = 4;
   localparam int DIV_STEPS = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        mul_valid;
   logic [31:0] mul_result;

   xalu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_STEPS(DIV_STEPS)) dut (
      .clk        (clk),
      .reset      (reset),
      .op_valid   (op_valid),
      .op         (op),
      .src_a      (src_a),
      .src_b      (src_b),
      .flush      (flush),
      .busy       (busy),
      .hi         (hi),
      .lo         (lo),
      .mul_valid  (mul_valid),
      .mul_result (mul_result)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // Reference model state
   int          m_left;
   logic [2:0]  m_op;
   logic [31:0] m_a, m_b;
   logic [31:0] m_hi, m_lo, m_mres;
   logic        m_mv;

`ifdef XALU_DIV_ZERO_FAST_EN
   localparam bit FAST_DZ = 1'b1;
`else
   localparam bit FAST_DZ = 1'b0;
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result of a completed MULT/MULTU/MUL/DIV/DIVU
   task automatic calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rh, output logic [31:0] rl);
      longint      ps;
      logic [63:0] pu;
      int          qs, rs;
      rh = 32'd0;
      rl = 32'd0;
      case (o)
         3'd0, 3'd6: begin
            ps = longint'($signed(a)) * longint'($signed(b));
            pu = 64'(ps);
            rh = pu[63:32];
            rl = pu[31:0];
         end
         3'd1: begin
            pu = {32'd0, a} * {32'd0, b};
            rh = pu[63:32];
            rl = pu[31:0];
         end
         3'd2: begin
            if (b == 32'd0) begin
               rl = 32'hFFFF_FFFF; rh = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               rl = 32'h8000_0000; rh = 32'd0;
            end else begin
               qs = $signed(a) / $signed(b);
               rs = $signed(a) % $signed(b);
               rl = qs; rh = rs;
            end
         end
         3'd3: begin
            if (b == 32'd0) begin
               rl = 32'hFFFF_FFFF; rh = a;
            end else begin
               rl = a / b; rh = a % b;
            end
         end
         default: ;
      endcase
   endtask

   // Advance the model by one rising edge using the inputs the DUT just sampled
   task automatic model_update();
      logic [31:0] rh, rl;
      if (reset) begin
         m_left = 0; m_hi = 0; m_lo = 0; m_mres = 0; m_mv = 0;
      end else begin
         m_mv = 1'b0;
         if (m_left > 0) begin
            if (flush) begin
               m_left = 0;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  calc(m_op, m_a, m_b, rh, rl);
                  if (m_op == 3'd6) begin
                     m_mres = rl; m_mv = 1'b1;
                  end else begin
                     m_hi = rh; m_lo = rl;
                  end
               end
            end
         end else if (op_valid && !flush && op != 3'd7) begin
            m_op = op; m_a = src_a; m_b = src_b;
            case (op)
               3'd4: m_hi = src_a;
               3'd5: m_lo = src_a;
               3'd0, 3'd1, 3'd6: m_left = MUL_LAT;
               3'd2, 3'd3: m_left = (FAST_DZ && src_b == 32'd0) ? 1 : DIV_STEPS + 1;
               default: ;
            endcase
         end
      end
   endtask

   // Compare process: every output against the model, once per cycle
   always @(negedge clk) begin
      if (check_en) begin
         check("busy",       busy,       m_left > 0);
         check("hi",         hi,         m_hi);
         check("lo",         lo,         m_lo);
         check("mul_valid",  mul_valid,  m_mv);
         check("mul_result", mul_result, m_mres);
      end
   end

   // One clock: drive at negedge, model on posedge, return at next negedge
   task automatic step(input logic v, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic f, input logic r);
      op_valid = v; op = o; src_a = a; src_b = b; flush = f; reset = r;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   // Count busy cycles until idle; an expired bound is a failure
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         idle();
      end
      check("wait_idle_timeout", busy, 1'b0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   int n;

   initial begin
      op_valid = 0; op = 0; src_a = 0; src_b = 0; flush = 0; reset = 1;
      @(negedge clk);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      check_en = 1'b1;
      check("reset_busy", busy, 1'b0);
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_mres", {31'd0, mul_valid, mul_result}, 64'd0);

      // MTLO visible next cycle, never busy
      step(1'b1, 3'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
      check("mtlo_lo", lo, 32'h1234);
      check("mtlo_busy", busy, 1'b0);
      $display("MTLO a=1234 -> lo=%h busy=%b", lo, busy);

      // MULT / MULTU -3 * 7
      step(1'b1, 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
      wait_idle(n);
      check("mult_busy_cycles", n, MUL_LAT);
      check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      $display("MULT -3*7 busy=%0d hi=%h lo=%h", n, hi, lo);
      step(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
      wait_idle(n);
      check("multu_hilo", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
      $display("MULTU busy=%0d hi=%h lo=%h", n, hi, lo);

      // DIV -7/2, DIVU 100/7
      step(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      wait_idle(n);
      check("div_busy_cycles", n, DIV_STEPS + 1);
      check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      $display("DIV -7/2 busy=%0d hi=%h lo=%h", n, hi, lo);
      step(1'b1, 3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
      wait_idle(n);
      check("divu_hilo", {hi, lo}, {32'd2, 32'd14});
      $display("DIVU 100/7 busy=%0d hi=%h lo=%h", n, hi, lo);

      // Signed overflow
      step(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      wait_idle(n);
      check("div_ovf_hilo", {hi, lo}, {32'd0, 32'h8000_0000});
      $display("DIV ovf busy=%0d hi=%h lo=%h", n, hi, lo);

      // Divide by zero
      step(1'b1, 3'd3, 32'd5, 32'd0, 1'b0, 1'b0);
      wait_idle(n);
      check("divz_busy_cycles", n, FAST_DZ ? 1 : DIV_STEPS + 1);
      check("divz_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
      $display("DIVU 5/0 busy=%0d hi=%h lo=%h", n, hi, lo);

      // Flush at busy cycle 10 of a DIV, then MULT accepted straight away
      step(1'b1, 3'd2, 32'd1000, 32'd3, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) idle();
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      check("flush_busy", busy, 1'b0);
      check("flush_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
      $display("DIV flushed busy=%b hi=%h lo=%h", busy, hi, lo);
      step(1'b1, 3'd0, 32'd2, 32'd3, 1'b0, 1'b0);
      check("post_flush_accept", busy, 1'b1);
      wait_idle(n);
      check("post_flush_mult", {hi, lo}, {32'd0, 32'd6});
      $display("MULT 2*3 after flush busy=%0d hi=%h lo=%h", n, hi, lo);

      // Flush together with op_valid in IDLE drops the op
      step(1'b1, 3'd4, 32'hABC, 32'd0, 1'b1, 1'b0);
      check("flush_idle_drop", hi, 32'd0);
      $display("MTHI with flush -> hi=%h", hi);

      // Flush on the completion edge wins
      step(1'b1, 3'd0, 32'd9, 32'd9, 1'b0, 1'b0);
      for (int i = 0; i < MUL_LAT - 1; i++) idle();
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      check("flush_complete_busy", busy, 1'b0);
      check("flush_complete_hilo", {hi, lo}, {32'd0, 32'd6});
      $display("MULT flushed at completion hi=%h lo=%h", hi, lo);

      // MUL results go to mul_result only; op_valid while busy is ignored
      step(1'b1, 3'd6, 32'd3, 32'd5, 1'b0, 1'b0);
      wait_idle(n);
      check("mul_pulse", mul_valid, 1'b1);
      check("mul_res", mul_result, 32'd15);
      $display("MUL 3*5 busy=%0d mul_valid=%b mul_result=%h", n, mul_valid, mul_result);
      idle();
      check("mul_pulse_end", mul_valid, 1'b0);
      step(1'b1, 3'd6, 32'h10000, 32'h10000, 1'b0, 1'b0);
      step(1'b1, 3'd4, 32'hDEAD, 32'd0, 1'b0, 1'b0);
      wait_idle(n);
      check("mul_busy_rest", n, MUL_LAT - 1);
      check("mul_pulse2", mul_valid, 1'b1);
      check("mul_res2", mul_result, 32'd0);
      check("mul_hilo_kept", {hi, lo}, {32'd0, 32'd6});
      $display("MUL 10000*10000 mul_valid=%b mul_result=%h hi=%h lo=%h", mul_valid, mul_result, hi, lo);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         logic        v, f, r;
         logic [2:0]  o;
         logic [31:0] a, b;
         v = ($urandom_range(0, 99) < 60);
         o = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         f = ($urandom_range(0, 99) < 3);
         r = ($urandom_range(0, 999) < 3);
         step(v, o, a, b, f, r);
         if (v && !f && !r && !busy)
            $display("rand op=%0d a=%h b=%h hi=%h lo=%h", o, a, b, hi, lo);
      end
      wait_idle(n);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
